// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the write-back data cache: FSM encoding, default geometry, address field positions.
// No logic; imported by the cache top and its data array.
// Field layout of a byte address: {tag, set, word, byte_off}.
package dcache_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 3;
    localparam int ADDR_W            = 32;
    localparam int BYTE_OFF_LEN      = 2;
    localparam int WORD_LSB          = BYTE_OFF_LEN;

endpackage

// File: rtl/dcache_line_mem.sv
// Cache data array: one combinational read port, one byte-enabled write port.
// Latency: read 0 cycles (async), write lands on the next rising edge.
// Backpressure: none; the owning FSM arbitrates the single write port.
module dcache_line_mem #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       wbe,
    input  logic [31:0]      wdata
);

    logic [31:0] mem [2**IDX_W];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache between MEM stage and a word-wide memory port.
// Latency: hit 1 cycle (registered rd_data); miss = write-back beats (if dirty) + fill beats + 1.
// Backpressure: combinational miss stalls the core; memory beats wait on mem_ack with req/addr held.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = ADDR_W - BYTE_OFF_LEN - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int NSETS   = 1 << SET_ADDR_LEN;
    localparam int SET_LSB = WORD_LSB + LINE_ADDR_LEN;
    localparam int TAG_LSB = SET_LSB + SET_ADDR_LEN;
    localparam int IDX_W   = SET_ADDR_LEN + LINE_ADDR_LEN;

    logic [LINE_ADDR_LEN-1:0] req_word;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic                     unused_byte_off;

    assign req_word        = addr[SET_LSB-1:WORD_LSB];
    assign req_set         = addr[TAG_LSB-1:SET_LSB];
    assign req_tag         = addr[ADDR_W-1:TAG_LSB];
    assign unused_byte_off = ^addr[BYTE_OFF_LEN-1:0];

    state_t                   state, state_nxt;
    logic [LINE_ADDR_LEN-1:0] cnt, cnt_nxt;
    logic [SET_ADDR_LEN-1:0]  miss_set;
    logic [TAG_ADDR_LEN-1:0]  miss_tag;
    logic [NSETS-1:0]         valid, dirty;
    logic [TAG_ADDR_LEN-1:0]  tag_arr [NSETS];

    logic req, hit, store_hit, load_hit, start_miss, last_beat, fill_done;

    assign req        = rd_req | wr_req;
    assign hit        = (state == ST_IDLE) & req & valid[req_set] & (tag_arr[req_set] == req_tag);
    assign store_hit  = hit & wr_req;
    assign load_hit   = hit & rd_req & ~wr_req;
    assign start_miss = (state == ST_IDLE) & req & ~hit;
    assign last_beat  = (cnt == {LINE_ADDR_LEN{1'b1}});
    assign fill_done  = (state == ST_FILL) & mem_ack & last_beat;
    assign miss       = (state != ST_IDLE) | (req & ~hit);

    logic [IDX_W-1:0] lm_raddr, lm_waddr;
    logic [31:0]      lm_rdata, lm_wdata;
    logic [3:0]       lm_wbe;
    logic             lm_we;

    dcache_line_mem #(.IDX_W(IDX_W)) u_line_mem (
        .clk   (clk),
        .raddr (lm_raddr),
        .rdata (lm_rdata),
        .we    (lm_we),
        .waddr (lm_waddr),
        .wbe   (lm_wbe),
        .wdata (lm_wdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        lm_raddr  = {req_set, req_word};
        lm_we     = 1'b0;
        lm_waddr  = {req_set, req_word};
        lm_wbe    = wr_be;
        lm_wdata  = wr_data;
        case (state)
            ST_IDLE: begin
                lm_we = store_hit;
                if (start_miss) begin
                    cnt_nxt   = '0;
                    state_nxt = (valid[req_set] & dirty[req_set]) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[miss_set], miss_set, cnt, 2'b00};
                lm_raddr  = {miss_set, cnt};
                mem_wdata = lm_rdata;
                if (mem_ack) begin
                    cnt_nxt = cnt + 1'b1;
                    if (last_beat) state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_set, cnt, 2'b00};
                if (mem_ack) begin
                    cnt_nxt  = cnt + 1'b1;
                    lm_we    = 1'b1;
                    lm_waddr = {miss_set, cnt};
                    lm_wbe   = 4'hF;
                    lm_wdata = mem_rdata;
                    if (last_beat) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            miss_set <= '0;
            miss_tag <= '0;
            valid    <= '0;
            dirty    <= '0;
            rd_data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Latch the missing line so a dropped/changed request cannot redirect the burst.
            if (start_miss) begin
                miss_set <= req_set;
                miss_tag <= req_tag;
            end
            if (load_hit)  rd_data <= lm_rdata;
            if (store_hit) dirty[req_set] <= 1'b1;
            if (fill_done) begin
                valid[miss_set] <= 1'b1;
                dirty[miss_set] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) tag_arr[miss_set] <= miss_tag;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's MEM stage and a word-wide main-memory port.
- Replaces the single-cycle data RAM behind the MEM/WB data register.
- Services hits with one-cycle registered read data.
- On a miss it raises `miss`; the hazard unit uses `miss` to bubble all stages. The cache then runs a line write-back (if dirty) and a line fill, one word per memory beat.

Parameters:
- `LINE_ADDR_LEN`, default 3: log2 of words per line (8 words).
- `SET_ADDR_LEN`, default 3: log2 of number of lines (8 lines).
- `TAG_ADDR_LEN`, default 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (derived; do not override).

Ports:
- `clk` input 1: core clock, rising edge.
- `rst` input 1: reset, asynchronous assert, active-low.
- `rd_req` input 1: load request from MEM stage.
- `wr_req` input 1: store request from MEM stage.
- `addr` input 32: byte address; bits [1:0] ignored.
- `wr_data` input 32: store data, already lane-aligned.
- `wr_be` input 4: byte enables for a store.
- `rd_data` output 32: load word, registered.
- `miss` output 1: stall request to the hazard unit, combinational.
- `mem_req` output 1: memory beat request.
- `mem_we` output 1: 1 = write beat, 0 = read beat.
- `mem_addr` output 32: word-aligned beat address.
- `mem_wdata` output 32: write-beat data.
- `mem_rdata` input 32: read-beat data, valid with `mem_ack`.
- `mem_ack` input 1: one-cycle beat completion pulse.

Behaviour:
- **Address split:** `addr[1:0]` byte offset; then word-in-line (`LINE_ADDR_LEN`), set index (`SET_ADDR_LEN`), tag (upper bits).
- **Per-line storage:** valid bit, dirty bit, tag, and `2^LINE_ADDR_LEN` data words.
- **Reset (rst=0, async):**
  - All valid and dirty bits cleared; FSM to IDLE; word counter 0.
  - `rd_data` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `miss` = 0 (no request) while in IDLE.
  - Data and tag arrays are not cleared.
  - Reset mid-burst abandons the burst: `mem_req` drops asynchronously.
- **FSM states:** IDLE, WRITEBACK, FILL.
- **Hit:** `hit = (rd_req | wr_req) & valid[set] & tag[set]==tag(addr)`, valid only in IDLE.
- **`miss` (combinational):** `(rd_req | wr_req) & ~hit`, or state != IDLE.
- **IDLE, load hit:** next edge `rd_data` <= line word. Latency 1; no stall.
- **IDLE, store hit:** next edge, merge `wr_data` into the word per `wr_be` and set dirty. `rd_data` holds its previous value.
- **IDLE, miss, victim valid & dirty:** go to WRITEBACK with counter 0.
- **IDLE, miss, otherwise:** go to FILL with counter 0.
- **WRITEBACK:**
  - Drive `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, set, counter, 2'b00}; `mem_wdata` = victim word[counter].
  - Each `mem_ack`: counter+1. On the ack of the last word: counter 0, go to FILL.
- **FILL:**
  - Drive `mem_req`=1, `mem_we`=0; `mem_addr` = {req tag, set, counter, 2'b00}.
  - Each `mem_ack`: write `mem_rdata` to word[counter], counter+1.
  - On the last ack: valid=1, dirty=0, tag updated, go to IDLE.
- **After refill:** the core is still stalled and holding its request. The next IDLE cycle hits and completes normally, so total miss penalty = beats + 1 cycle.
- **Memory handshake:**
  - `mem_req` and `mem_addr` are held stable until `mem_ack`.
  - `mem_ack` while `mem_req`=0 is ignored.
  - `mem_ack` may arrive in the same cycle as `mem_req` rises (zero wait).
- **`rd_req` & `wr_req` both high:** treated as a store; `rd_data` is not updated.
- **Requests dropped mid-miss:** ignored until IDLE; the in-flight write-back/fill still completes.
- **No request in IDLE:** no state change; `rd_data` holds.
- Counter width = `LINE_ADDR_LEN`; counter wraps to 0 at the end of each burst.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, WRITEBACK=1, FILL=2).
  - Default `LINE_ADDR_LEN` and `SET_ADDR_LEN`.
  - Address-field slice helper constants.
- One natural sub-module, `dcache_line_mem`: the data array with one read port and one byte-enabled write port, shared by hit-write and fill. Tag/valid/dirty arrays and the FSM stay in the top.

Test Plan:
1. Reset, then load at 0x0000_0040 with memory word k = 0x1000+k, ack every cycle:
   - `miss`=1 for 9 cycles (8 FILL beats, `mem_we`=0, `mem_addr` 0x40..0x5C), then hit.
   - Next edge `rd_data`=0x1000+0x10 (word 0x10 of the 0x40 fill pattern); `miss`=0.
2. Store 0xDEADBEEF with `wr_be`=4'b0011 to 0x44 (hit), then load 0x44:
   - `rd_data` = {0x1000+0x11 upper half, 0xBEEF} = 0x0000BEEF; no stall.
3. Load 0x0000_0440 (same set, different tag, victim dirty):
   - 8 write beats (`mem_we`=1, `mem_addr` 0x40..0x5C, `mem_wdata` at 0x44 = 0x0000BEEF).
   - Then 8 read beats at 0x440..0x45C, then hit.
4. Memory acks every 3rd cycle during FILL:
   - `mem_addr`/`mem_req` held stable between acks.
   - Fill completes after 24 cycles; loaded data correct.
5. Assert rst=0 during beat 4 of FILL:
   - `mem_req`=0 immediately; state IDLE.
   - A reload of the same address misses again (line invalid).
6. `rd_req`=`wr_req`=1 on a hit:
   - Word is written per `wr_be`; `rd_data` unchanged; dirty set.
